// File: rtl/pc_gen_ras_pkg.sv
// Shared definitions for the PC generator: next-PC select encodings and default vectors.
package pc_gen_ras_pkg;

  localparam int unsigned NPC_SEL_W = 3;

  localparam logic [NPC_SEL_W-1:0] NPC_SEQ  = 3'b000;
  localparam logic [NPC_SEL_W-1:0] NPC_J    = 3'b001;
  localparam logic [NPC_SEL_W-1:0] NPC_JAL  = 3'b010;
  localparam logic [NPC_SEL_W-1:0] NPC_JR   = 3'b011;
  localparam logic [NPC_SEL_W-1:0] NPC_BEQ  = 3'b100;
  localparam logic [NPC_SEL_W-1:0] NPC_BNE  = 3'b101;
  localparam logic [NPC_SEL_W-1:0] NPC_RET  = 3'b110;
  localparam logic [NPC_SEL_W-1:0] NPC_ERET = 3'b111;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] count;

  // ptr names the next free slot; the top of stack sits just below it
  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == CNT_W'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != CNT_W'(RAS_DEPTH)) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage needs no reset: count gates every read that matters
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Program counter with next-PC selection, exception/eret handling and a
// return-address stack that flags mispredicted jr-$ra returns.
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(EXC_VEC_DEF),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       npc_sel,
  input  logic [25:0]      imm26,
  input  logic [15:0]      imm16,
  input  logic             zero,
  input  logic [WIDTH-1:0] gpr_in,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_4,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] epc,
  output logic             ras_miss,
  output logic             ras_empty
);

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             advance;
  logic             ras_push;
  logic             ras_pop;
  logic             miss_d;

  assign pc_4   = pc + WIDTH'(4);
  assign br_off = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign br_tgt = pc_4 + br_off;
  assign j_tgt  = {pc[WIDTH-1:28], imm26, 2'b00};

  always_comb begin
    npc = pc_4;
    case (npc_sel)
      NPC_J, NPC_JAL:  npc = j_tgt;
      NPC_JR, NPC_RET: npc = gpr_in;
      NPC_BEQ:         npc = zero ? br_tgt : pc_4;
      NPC_BNE:         npc = zero ? pc_4 : br_tgt;
      NPC_ERET:        npc = epc;
      default:         npc = pc_4;
    endcase
    if (exc_req) npc = EXC_VEC;
  end

  // RAS only moves on edges where the PC actually advances through npc
  assign advance  = !stall && !exc_req;
  assign ras_push = advance && (npc_sel == NPC_JAL);
  assign ras_pop  = advance && (npc_sel == NPC_RET);
  assign miss_d   = ras_pop && (ras_empty || (ras_top != gpr_in));

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .WIDTH     (WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      epc      <= '0;
      ras_miss <= 1'b0;
    end else begin
      ras_miss <= miss_d;
      if (exc_req) begin
        pc  <= EXC_VEC;
        epc <= pc;
      end else if (!stall) begin
        pc <= npc;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: queue-based reference model checked every cycle plus directed literals.
module tb_pc_gen_ras;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  npc_sel;
  logic [25:0] imm26;
  logic [15:0] imm16;
  logic        zero;
  logic [31:0] gpr_in;
  logic        exc_req;
  logic [31:0] pc, pc_4, npc, epc;
  logic        ras_miss, ras_empty;

  int n_total = 0;
  int n_pass  = 0;

  pc_gen_ras #(.WIDTH(32), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .npc_sel(npc_sel), .imm26(imm26),
    .imm16(imm16), .zero(zero), .gpr_in(gpr_in), .exc_req(exc_req), .pc(pc),
    .pc_4(pc_4), .npc(npc), .epc(epc), .ras_miss(ras_miss), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural PC/EPC and the RAS as a bounded queue
  logic [31:0] m_pc, m_epc;
  logic        m_miss;
  logic [31:0] m_ras[$];

  function automatic logic [31:0] model_npc();
    int off;
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    off = int'($signed(imm16)) * 4;
    if (exc_req) return 32'h0000_4180;
    case (npc_sel)
      3'd1, 3'd2: return (m_pc & 32'hF000_0000) | (32'(imm26) * 32'd4);
      3'd3, 3'd6: return gpr_in;
      3'd4:       return zero ? seq + 32'(off) : seq;
      3'd5:       return !zero ? seq + 32'(off) : seq;
      3'd7:       return m_epc;
      default:    return seq;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nxt;
    logic [31:0] popped;
    if (!rst_n) begin
      m_pc = 32'h0000_3000; m_epc = '0; m_miss = 1'b0;
      m_ras.delete();
    end else begin
      nxt    = model_npc();
      m_miss = 1'b0;
      if (exc_req) begin
        m_epc = m_pc;
        m_pc  = 32'h0000_4180;
      end else if (!stall) begin
        if (npc_sel == 3'd2) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (npc_sel == 3'd6) begin
          if (m_ras.size() == 0) m_miss = 1'b1;
          else begin
            popped = m_ras.pop_back();
            m_miss = (popped != gpr_in);
          end
        end
        m_pc = nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pc", pc, m_pc);
      chk("pc_4", pc_4, m_pc + 32'd4);
      chk("npc", npc, model_npc());
      chk("epc", epc, m_epc);
      chk("ras_miss", 32'(ras_miss), 32'(m_miss));
      chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    end
  end

  task automatic step(input logic [2:0] s, input logic [25:0] i26, input logic [15:0] i16,
                      input logic z, input logic [31:0] g, input logic e, input logic st);
    npc_sel = s; imm26 = i26; imm16 = i16; zero = z; gpr_in = g; exc_req = e; stall = st;
    @(posedge clk);
    #1;
  endtask

  task automatic seq1();
    step(3'd0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; npc_sel = 3'd0; imm26 = '0; imm16 = '0;
    zero = 1'b0; gpr_in = '0; exc_req = 1'b0;
    #12 rst_n = 1'b1;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_miss", 32'(ras_miss), 32'd0);

    seq1(); chk("seq1", pc, 32'h3004);
    seq1(); chk("seq2", pc, 32'h3008);
    seq1(); chk("seq3", pc, 32'h300C);
    seq1(); chk("seq4", pc, 32'h3010);

    step(3'd4, '0, 16'hFFFF, 1'b1, '0, 1'b0, 1'b0); chk("beq_taken", pc, 32'h3010);
    step(3'd5, '0, 16'h0002, 1'b0, '0, 1'b0, 1'b0); chk("bne_taken", pc, 32'h301C);
    step(3'd4, '0, 16'h0002, 1'b0, '0, 1'b0, 1'b0); chk("beq_not", pc, 32'h3020);

    step(3'd0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    chk("exc_pc", pc, 32'h4180);
    chk("exc_epc", epc, 32'h3020);
    seq1(); chk("post_exc1", pc, 32'h4184);
    seq1(); chk("post_exc2", pc, 32'h4188);
    step(3'd7, '0, '0, 1'b0, '0, 1'b0, 1'b0); chk("eret", pc, 32'h3020);

    step(3'd3, '0, '0, 1'b0, 32'h3000, 1'b0, 1'b0); chk("jr", pc, 32'h3000);
    chk("jr_ras_empty", 32'(ras_empty), 32'd1);
    step(3'd2, 26'h0000C40, '0, 1'b0, '0, 1'b0, 1'b0); chk("jal", pc, 32'h3100);
    chk("jal_nonempty", 32'(ras_empty), 32'd0);
    step(3'd6, '0, '0, 1'b0, 32'h3004, 1'b0, 1'b0); chk("ret", pc, 32'h3004);
    chk("ret_hit", 32'(ras_miss), 32'd0);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    step(3'd2, 26'h0000C80, '0, 1'b0, '0, 1'b0, 1'b1); chk("stall_pc", pc, 32'h3004);
    chk("stall_ras", 32'(ras_empty), 32'd1);

    // Five calls into a four-entry stack: the oldest return address is lost
    step(3'd2, 26'h0000C80, '0, 1'b0, '0, 1'b0, 1'b0); chk("call1", pc, 32'h3200);
    step(3'd2, 26'h0000CC0, '0, 1'b0, '0, 1'b0, 1'b0); chk("call2", pc, 32'h3300);
    step(3'd2, 26'h0000D00, '0, 1'b0, '0, 1'b0, 1'b0); chk("call3", pc, 32'h3400);
    step(3'd2, 26'h0000D40, '0, 1'b0, '0, 1'b0, 1'b0); chk("call4", pc, 32'h3500);
    step(3'd2, 26'h0000D80, '0, 1'b0, '0, 1'b0, 1'b0); chk("call5", pc, 32'h3600);
    step(3'd6, '0, '0, 1'b0, 32'h3504, 1'b0, 1'b0); chk("r1_miss", 32'(ras_miss), 32'd0);
    step(3'd6, '0, '0, 1'b0, 32'h3404, 1'b0, 1'b0); chk("r2_miss", 32'(ras_miss), 32'd0);
    step(3'd6, '0, '0, 1'b0, 32'h3304, 1'b0, 1'b0); chk("r3_miss", 32'(ras_miss), 32'd0);
    step(3'd6, '0, '0, 1'b0, 32'h3204, 1'b0, 1'b0); chk("r4_miss", 32'(ras_miss), 32'd0);
    chk("r4_pc", pc, 32'h3204);
    chk("r4_empty", 32'(ras_empty), 32'd1);
    step(3'd6, '0, '0, 1'b0, 32'h3008, 1'b0, 1'b0); chk("r5_miss", 32'(ras_miss), 32'd1);
    chk("r5_pc", pc, 32'h3008);
    chk("r5_empty", 32'(ras_empty), 32'd1);
    seq1(); chk("miss_pulse_end", 32'(ras_miss), 32'd0);

    step(3'd2, 26'h0000C40, '0, 1'b0, '0, 1'b0, 1'b0); chk("jal2", pc, 32'h3100);
    step(3'd6, '0, '0, 1'b0, 32'h3050, 1'b0, 1'b0); chk("wrong_ret_pc", pc, 32'h3050);
    chk("wrong_ret_miss", 32'(ras_miss), 32'd1);

    step(3'd3, '0, '0, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0);
    step(3'd4, '0, 16'h0001, 1'b1, '0, 1'b0, 1'b0); chk("br_wrap", pc, 32'h0000_0000);

    // Asynchronous reset in the middle of a stalled cycle
    step(3'd2, 26'h0000C40, '0, 1'b0, '0, 1'b0, 1'b0); chk("jal3", pc, 32'h3100);
    step(3'd0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h3000);
    chk("mid_rst_empty", 32'(ras_empty), 32'd1);
    chk("mid_rst_epc", epc, 32'h0);
    #1 rst_n = 1'b1;
    step(3'd6, '0, '0, 1'b0, 32'h1234, 1'b0, 1'b0); chk("post_rst_pc", pc, 32'h1234);
    chk("post_rst_miss", 32'(ras_miss), 32'd1);
    seq1();
    seq1();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
